// File: rtl/twos_comp_pkg.sv
// Shared constants for the serial two's complement controller: state encoding
// and default operand width.
package twos_comp_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned STATE_W       = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_SHIFT = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/twos_comp_bit_cell.sv
// One-bit Mealy negation cell: passes bits through up to and including the
// first 1, then inverts every later bit.
module twos_comp_bit_cell (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic b,
    output logic q
);

    logic seen_one_q;
    logic seen_one_d;

    always_comb begin
        seen_one_d = seen_one_q;
        if (clr) begin
            seen_one_d = 1'b0;
        end else if (en) begin
            seen_one_d = seen_one_q | b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seen_one_q <= 1'b0;
        end else begin
            seen_one_q <= seen_one_d;
        end
    end

    assign q = b ^ seen_one_q;

endmodule

// File: rtl/twos_comp_seq_ctrl.sv
// Parallel-in/parallel-out sequencer around the bit-serial negation cell:
// accepts a word, streams it LSB-first through the cell, returns the result.
module twos_comp_seq_ctrl
    import twos_comp_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [STATE_W-1:0] state_q,   state_d;
    logic [WIDTH-1:0]   opnd_q,    opnd_d;
    logic [WIDTH-1:0]   res_q,     res_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               opnd_msb_q, opnd_msb_d;
    logic [WIDTH-1:0]   dout_q,    dout_d;
    logic               ovf_q,     ovf_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic cell_clr;
    logic cell_en;
    logic cell_q;

    twos_comp_bit_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .clr   (cell_clr),
        .en    (cell_en),
        .b     (opnd_q[0]),
        .q     (cell_q)
    );

    // Next-state and registered-output logic; busy/done anticipate the next state.
    always_comb begin
        state_d    = state_q;
        opnd_d     = opnd_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        opnd_msb_d = opnd_msb_q;
        dout_d     = dout_q;
        ovf_d      = ovf_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        cell_clr   = 1'b0;
        cell_en    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    opnd_d     = din;
                    cnt_d      = '0;
                    opnd_msb_d = din[WIDTH-1];
                    cell_clr   = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cell_en = 1'b1;
                opnd_d  = opnd_q >> 1;
                res_d   = {cell_q, res_q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    // The final emitted bit is the result MSB.
                    dout_d  = {cell_q, res_q[WIDTH-1:1]};
                    ovf_d   = opnd_msb_q & cell_q;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            opnd_q     <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            opnd_msb_q <= 1'b0;
            dout_q     <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            opnd_q     <= opnd_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            opnd_msb_q <= opnd_msb_d;
            dout_q     <= dout_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign dout     = dout_q;
    assign overflow = ovf_q;

endmodule

// File: doc/twos_comp_seq_ctrl.md
# twos_comp_seq_ctrl

Sequencing controller for the serial two's complement datapath. It accepts a parallel word on a start handshake, streams it LSB-first through a one-bit Mealy negation cell, and collects the serial result back into a parallel word. When the result is ready it pulses `done` and flags overflow for the most-negative input. It sits between parallel register-file style producers and the bit-serial negation engine, so that engine never sees raw bit streams from the outside.

## Interface
- `WIDTH`, default 8, operand/result width in bits; legal range 2..32.
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `start`  input  1  request to negate `din`; honoured only in IDLE or DONE.
- `din`  input  WIDTH  operand, sampled on the accepting edge only.
- `busy`  output  1  high while a conversion is in progress (SHIFT state).
- `done`  output  1  one-cycle pulse when `dout` and `overflow` become valid.
- `dout`  output  WIDTH  two's complement of the last accepted `din`; held until the next accept.
- `overflow`  output  1  set when the result is unrepresentable (`din` = 100…0); held with `dout`.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `busy`=0, `done`=0. On `start`=1:
  - load `din` into the operand shift register;
  - clear the bit counter and the cell's `seen_one` flag;
  - go to SHIFT.
- SHIFT: `busy`=1, one bit per cycle.
  - The cell takes operand bit 0 and emits `b XOR seen_one`, then sets `seen_one` to `seen_one OR b`. This gives unchanged bits up to and including the first 1, then inverted bits.
  - The operand shifts right by one.
  - The emitted bit shifts into the result register from the MSB side, so after WIDTH shifts bit i lands at position i.
  - The counter increments. When it reaches WIDTH-1 on this edge, go to DONE.
- DONE: one cycle.
  - `done`=1 and `busy`=0.
  - `dout` is the result register.
  - `overflow` is the original operand MSB AND the result MSB; the controller keeps the operand MSB in a flag captured at accept.
  - Next state is IDLE. If `start`=1 in this cycle, the request is accepted exactly as in IDLE and the next state is SHIFT.
- `start` during SHIFT is ignored and is not queued. `din` changes outside the accepting edge have no effect.
- Zero operand: `seen_one` never sets, so `dout`=0 and `overflow`=0.
- Arithmetic is modulo 2^WIDTH. The counter is `$clog2(WIDTH)` bits wide and never wraps in normal operation.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `dout`=0, `overflow`=0, counter 0, `seen_one`=0, shift registers 0.
- Reset mid-operation: everything returns to the reset values on that edge. The aborted result is discarded and no `done` is issued.
- `reset` and `start` together: reset wins.
- Latency, with start accepted on edge 0:
  - SHIFT occupies cycles 1..WIDTH;
  - `done` is high in cycle WIDTH+1;
  - WIDTH=8 gives `done` in cycle 9.
- Throughput: one conversion per WIDTH+1 cycles when `start` is held high continuously, because DONE cycles are overlapped by back-to-back accepts.
- `dout`/`overflow` update only on the DONE-entry edge and are stable otherwise.

## Structure
- Shared package `twos_comp_pkg`:
  - state encoding localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2); 2'd3 is illegal and recovers to IDLE;
  - default `WIDTH`.
- Sub-module `twos_comp_bit_cell`:
  - ports: `clk`, `reset`, `clr`, `en`, `b`, `q`;
  - `q` is combinational `b ^ seen_one`;
  - `seen_one` is registered, cleared by `reset` or `clr`, and updated only when `en`=1;
  - the controller drives `en` high in SHIFT.
- The controller owns the FSM, counter, operand/result shift registers and the overflow flag.

## Test plan
- `din`=0x01 accepted at cycle 0 → `busy` high cycles 1–8, `done` pulse cycle 9, `dout`=0xFF, `overflow`=0.
- `din`=0x2C → `dout`=0xD4; `din`=0x00 → `dout`=0x00, `overflow`=0.
- `din`=0x80 → `dout`=0x80, `overflow`=1; next `din`=0x7F → `dout`=0x81, `overflow`=0.
- `start` pulsed with `din`=0x55 at cycle 3 of an active 0x01 conversion → ignored; result 0xFF, a single `done`, no extra conversion.
- `reset` at cycle 4 of a conversion → `busy`, `done`, `dout` all 0 next cycle. A fresh start with 0x02 then yields 0xFE after 9 cycles.
- `start` held high with `din`=0x03 then 0x04 → `done` at cycles 9 and 18, `dout` 0xFD then 0xFC.
